// File: rtl/result_queue_arb_pkg.sv
// result_queue_arb_pkg
//   Shared types and constants for the completion queue arbiter.
//   - result_t  : completion message (Result) carried through the queue
//   - ARB_FIXED : lowest-index channel wins
//   - ARB_RR    : round-robin starting at rr_ptr
//   - idx_w()   : width of a channel index, never less than 1 bit
package result_queue_arb_pkg;

   localparam int RESULT_W  = 49;
   typedef logic [RESULT_W-1:0] result_t;

   localparam int ARB_FIXED = 0;
   localparam int ARB_RR    = 1;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/result_queue_arb_fifo.sv
// rq_channel_fifo
//   Per-channel in-order FIFO with an asynchronous head read.
//   Ports:
//     clock, reset_n : clock, async active-low reset
//     flash          : synchronous discard of all contents
//     push / wdata   : write wdata at the tail
//     pop            : advance the head
//     head           : current head entry (valid while count != 0)
//     count          : occupancy, 0..DEPTH
module rq_channel_fifo #(
   parameter int DEPTH  = 32,
   parameter int DATA_W = 49,
   parameter int CW     = $clog2(DEPTH+1)
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              flash,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] head,
   output logic [CW-1:0]     count
);

   localparam int AW = $clog2(DEPTH);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q,  count_d;

   // Pointers are exactly log2(DEPTH) bits, so they wrap on their own.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flash) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         if (push && !pop)      count_d = count_q + CW'(1);
         else if (pop && !push) count_d = count_q - CW'(1);
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is not reset; count gates whether head is meaningful.
   always_ff @(posedge clock) begin
      if (push && !flash) mem_q[wr_ptr_q] <= wdata;
   end

   assign head  = mem_q[rd_ptr_q];
   assign count = count_q;

endmodule

// File: rtl/result_queue_arb.sv
// result_queue_arb
//   NUM_Q-channel completion queue: one FIFO per channel, an arbiter that
//   drains one message per cycle into a registered output stage, and an
//   empty-channel bypass straight into that stage.
//   Ports:
//     clock, reset_n : clock, async active-low reset
//     flash          : synchronous flush, discards everything
//     in_en/in_data  : per-channel message offer (channel i at [i*DATA_W +: DATA_W])
//     in_reject      : per-channel refusal (combinational from out_reject)
//     out_en/out_data: registered output message
//     out_reject     : downstream refusal
//     q_count        : per-channel registered occupancy, CW bits each
module result_queue_arb
   import result_queue_arb_pkg::*;
#(
   parameter  int NUM_Q    = 7,
   parameter  int DEPTH    = 32,
   parameter  int DATA_W   = RESULT_W,
   parameter  int ARB_MODE = ARB_FIXED,
   localparam int CW       = $clog2(DEPTH+1)
) (
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic                    flash,
   input  logic [NUM_Q-1:0]        in_en,
   input  logic [NUM_Q*DATA_W-1:0] in_data,
   output logic [NUM_Q-1:0]        in_reject,
   output logic                    out_en,
   output logic [DATA_W-1:0]       out_data,
   input  logic                    out_reject,
   output logic [NUM_Q*CW-1:0]     q_count
);

   localparam int QW = idx_w(NUM_Q);

   logic [NUM_Q-1:0][DATA_W-1:0] head;
   logic [NUM_Q-1:0][CW-1:0]     cnt;
   logic [NUM_Q-1:0]             nonempty, cand, pop, byp, push;

   logic              out_valid_q, out_valid_d;
   logic [DATA_W-1:0] out_data_q,  out_data_d;
   logic [QW-1:0]     rr_ptr_q,    rr_ptr_d;

   logic              load, gnt_any, gnt_vld;
   logic [QW-1:0]     gnt_idx;
   logic [DATA_W-1:0] gnt_data;

   // Stage takes a new message when empty or when the held one is consumed.
   assign load    = ~out_valid_q | ~out_reject;
   assign gnt_vld = load & gnt_any & ~flash;

   // Candidate scan. Fixed mode scans downward so the lowest index is the
   // last writer; RR mode takes the first candidate at or after rr_ptr.
   always_comb begin
      int j;
      j        = 0;
      gnt_any  = 1'b0;
      gnt_idx  = '0;
      gnt_data = '0;
      if (ARB_MODE == ARB_RR) begin
         for (int k = 0; k < NUM_Q; k++) begin
            j = (int'(rr_ptr_q) + k) % NUM_Q;
            if (!gnt_any && cand[j]) begin
               gnt_any = 1'b1;
               gnt_idx = QW'(j);
            end
         end
      end else begin
         for (int k = NUM_Q-1; k >= 0; k--) begin
            if (cand[k]) begin
               gnt_any = 1'b1;
               gnt_idx = QW'(k);
            end
         end
      end
      // Head outranks new input, keeping per-channel order.
      for (int i = 0; i < NUM_Q; i++) begin
         if (gnt_idx == QW'(i))
            gnt_data = nonempty[i] ? head[i] : in_data[i*DATA_W +: DATA_W];
      end
   end

   for (genvar i = 0; i < NUM_Q; i++) begin : g_ch
      assign nonempty[i] = (cnt[i] != '0);
      assign cand[i]     = nonempty[i] | in_en[i];
      assign pop[i]      = gnt_vld & (gnt_idx == QW'(i)) &  nonempty[i];
      assign byp[i]      = gnt_vld & (gnt_idx == QW'(i)) & ~nonempty[i];
      // A full channel still accepts when its head leaves this cycle.
      // During flush nothing is refused; the input is silently dropped.
      assign in_reject[i] = ~reset_n
                          | (~flash & (cnt[i] == CW'(DEPTH)) & ~pop[i]);
      // A bypassed input never enters the FIFO.
      assign push[i]     = in_en[i] & ~in_reject[i] & ~flash & ~byp[i];
      assign q_count[i*CW +: CW] = cnt[i];

      rq_channel_fifo #(
         .DEPTH  (DEPTH),
         .DATA_W (DATA_W),
         .CW     (CW)
      ) u_fifo (
         .clock   (clock),
         .reset_n (reset_n),
         .flash   (flash),
         .push    (push[i]),
         .pop     (pop[i]),
         .wdata   (in_data[i*DATA_W +: DATA_W]),
         .head    (head[i]),
         .count   (cnt[i])
      );
   end

   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      rr_ptr_d    = rr_ptr_q;
      if (flash) begin
         out_valid_d = 1'b0;
         rr_ptr_d    = '0;
      end else if (load) begin
         out_valid_d = gnt_any;
         if (gnt_any) begin
            out_data_d = gnt_data;
            rr_ptr_d   = (gnt_idx == QW'(NUM_Q-1)) ? '0 : gnt_idx + QW'(1);
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         rr_ptr_q    <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         rr_ptr_q    <= rr_ptr_d;
      end
   end

   assign out_en   = out_valid_q & ~flash;
   assign out_data = out_data_q;

endmodule

// File: tb/tb_result_queue_arb.sv
// tb_result_queue_arb
//   Two instances: dut0 fixed priority with DEPTH=2, dut1 round-robin with
//   DEPTH=4, both with three 16-bit channels. Output messages are checked
//   against per-instance scoreboard queues on every accepted transfer.
module tb_result_queue_arb;

   localparam int W   = 16;
   localparam int NQ  = 3;
   localparam int CW0 = $clog2(2+1);
   localparam int CW1 = $clog2(4+1);

   logic clock = 1'b0;
   logic rst_n, flash;

   logic [NQ-1:0]     in_en0, in_rej0, in_en1, in_rej1;
   logic [NQ*W-1:0]   in_data0, in_data1;
   logic              out_en0, out_rej0, out_en1, out_rej1;
   logic [W-1:0]      out_data0, out_data1;
   logic [NQ*CW0-1:0] q0;
   logic [NQ*CW1-1:0] q1;

   int vecs  = 0;
   int fails = 0;
   logic [W-1:0] exp0[$];
   logic [W-1:0] exp1[$];

   always #5 clock = ~clock;

   result_queue_arb #(.NUM_Q(NQ), .DEPTH(2), .DATA_W(W), .ARB_MODE(0)) dut0 (
      .clock(clock), .reset_n(rst_n), .flash(flash),
      .in_en(in_en0), .in_data(in_data0), .in_reject(in_rej0),
      .out_en(out_en0), .out_data(out_data0), .out_reject(out_rej0),
      .q_count(q0));

   result_queue_arb #(.NUM_Q(NQ), .DEPTH(4), .DATA_W(W), .ARB_MODE(1)) dut1 (
      .clock(clock), .reset_n(rst_n), .flash(flash),
      .in_en(in_en1), .in_data(in_data1), .in_reject(in_rej1),
      .out_en(out_en1), .out_data(out_data1), .out_reject(out_rej1),
      .q_count(q1));

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vecs++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   // Scoreboard monitors: a transfer happens on the next edge when
   // out_en=1 and out_reject=0, sampled at the falling edge.
   always @(negedge clock) begin
      if (rst_n && out_en0 && !out_rej0) begin
         vecs++;
         assert (exp0.size() > 0) else begin
            fails++;
            $error("FAIL dut0_extra_output: got %0h with empty scoreboard", out_data0);
         end
         if (exp0.size() > 0) chk("dut0_out_data", 64'(out_data0), 64'(exp0.pop_front()));
      end
   end

   always @(negedge clock) begin
      if (rst_n && out_en1 && !out_rej1) begin
         vecs++;
         assert (exp1.size() > 0) else begin
            fails++;
            $error("FAIL dut1_extra_output: got %0h with empty scoreboard", out_data1);
         end
         if (exp1.size() > 0) chk("dut1_out_data", 64'(out_data1), 64'(exp1.pop_front()));
      end
   end

   initial begin
      int acc[NQ];
      int v;
      rst_n = 1'b0; flash = 1'b0;
      in_en0 = '0; in_data0 = '0; out_rej0 = 1'b0;
      in_en1 = '0; in_data1 = '0; out_rej1 = 1'b0;

      // ---- reset state
      #2;
      chk("rst_in_reject0", 64'(in_rej0), 64'(3'b111));
      chk("rst_out_en0",    64'(out_en0), 64'(0));
      chk("rst_out_data0",  64'(out_data0), 64'(0));
      chk("rst_q_count0",   64'(q0), 64'(0));
      chk("rst_q_count1",   64'(q1), 64'(0));
      cyc(2);
      rst_n = 1'b1;
      #1;
      chk("post_rst_in_reject0", 64'(in_rej0), 64'(0));

      // ---- bypass: ch1 one-cycle latency
      in_en0 = 3'b010; in_data0[1*W +: W] = 16'h01A5;
      exp0.push_back(16'h01A5);
      cyc(1);
      in_en0 = '0;
      chk("byp_out_en",   64'(out_en0), 64'(1));
      chk("byp_out_data", 64'(out_data0), 64'(16'h01A5));
      chk("byp_q_count",  64'(q0), 64'(0));
      cyc(1);
      chk("byp_drained", 64'(out_en0), 64'(0));

      // ---- fixed priority: ch2 queued before ch0/ch1, still drains after them
      out_rej0 = 1'b1;
      in_en0 = 3'b100; in_data0[2*W +: W] = 16'h0A0A;
      exp0.push_back(16'h0A0A);
      cyc(1);
      in_data0[2*W +: W] = 16'h0D0D;
      cyc(1);
      in_en0 = 3'b011; in_data0[0 +: W] = 16'h0B0B; in_data0[1*W +: W] = 16'h0C0C;
      exp0.push_back(16'h0B0B);
      exp0.push_back(16'h0C0C);
      exp0.push_back(16'h0D0D);
      cyc(1);
      in_en0 = '0;
      chk("fp_q_count", 64'(q0), 64'({2'd1, 2'd1, 2'd1}));
      chk("fp_hold_data", 64'(out_data0), 64'(16'h0A0A));
      out_rej0 = 1'b0;
      cyc(4);
      chk("fp_drained_en", 64'(out_en0), 64'(0));
      chk("fp_drained_q",  64'(q0), 64'(0));
      chk("fp_sb_empty",   64'(exp0.size()), 64'(0));

      // ---- full / accept-on-pop with DEPTH=2
      out_rej0 = 1'b1;
      exp0.push_back(16'h0010); exp0.push_back(16'h0011);
      exp0.push_back(16'h0012); exp0.push_back(16'h0013);
      in_en0 = 3'b001;
      in_data0[0 +: W] = 16'h0010; cyc(1);
      in_data0[0 +: W] = 16'h0011; cyc(1);
      in_data0[0 +: W] = 16'h0012; cyc(1);
      in_data0[0 +: W] = 16'h0013;
      @(negedge clock);
      chk("full_reject",  64'(in_rej0[0]), 64'(1));
      chk("full_q_count", 64'(q0), 64'(2));
      @(posedge clock); #1;
      out_rej0 = 1'b0;
      @(negedge clock);
      chk("full_accept_on_pop", 64'(in_rej0[0]), 64'(0));
      @(posedge clock); #1;
      in_en0 = '0;
      chk("full_count_stays", 64'(q0), 64'(2));
      cyc(3);
      chk("full_drained_en", 64'(out_en0), 64'(0));
      chk("full_drained_q",  64'(q0), 64'(0));
      chk("full_sb_empty",   64'(exp0.size()), 64'(0));

      // ---- round-robin fairness on dut1, all channels pushing every cycle
      for (int c = 0; c < NQ; c++) acc[c] = 0;
      for (int k = 0; k < 4; k++)
         for (int c = 0; c < NQ; c++) exp1.push_back(W'((c << 8) | k));
      in_en1 = 3'b111;
      for (int i = 0; i < 12; i++) begin
         for (int c = 0; c < NQ; c++) in_data1[c*W +: W] = W'((c << 8) | acc[c]);
         @(negedge clock);
         for (int c = 0; c < NQ; c++) if (!in_rej1[c]) acc[c]++;
         @(posedge clock); #1;
      end
      in_en1 = '0;
      for (int k = 4; k < 16; k++)
         for (int c = 0; c < NQ; c++) if (k < acc[c]) exp1.push_back(W'((c << 8) | k));
      cyc(20);
      chk("rr_sb_empty", 64'(exp1.size()), 64'(0));
      chk("rr_drained_q", 64'(q1), 64'(0));
      chk("rr_drained_en", 64'(out_en1), 64'(0));

      // ---- wrap and order through dut1 ch0 with random backpressure
      for (int k = 0; k < 10; k++) exp1.push_back(W'(k));
      v = 0;
      for (int c = 0; c < 200 && v < 10; c++) begin
         in_en1 = 3'b001;
         in_data1[0 +: W] = W'(v);
         out_rej1 = 1'($urandom_range(0, 1));
         @(negedge clock);
         if (!in_rej1[0]) v++;
         @(posedge clock); #1;
      end
      in_en1 = '0; out_rej1 = 1'b0;
      cyc(8);
      chk("wrap_accepted", 64'(v), 64'(10));
      chk("wrap_sb_empty", 64'(exp1.size()), 64'(0));
      chk("wrap_q_count",  64'(q1), 64'(0));

      // ---- flush with three queued entries and a held message
      out_rej0 = 1'b1;
      in_en0 = 3'b001; in_data0[0 +: W] = 16'h0020; cyc(1);
      in_data0[0 +: W] = 16'h0021; cyc(1);
      in_en0 = 3'b011; in_data0[0 +: W] = 16'h0022; in_data0[1*W +: W] = 16'h0031; cyc(1);
      chk("fl_pre_q",  64'(q0), 64'({2'd0, 2'd1, 2'd2}));
      chk("fl_pre_en", 64'(out_en0), 64'(1));
      in_en0 = 3'b101; in_data0[2*W +: W] = 16'h0099; in_data0[0 +: W] = 16'h0023;
      flash = 1'b1;
      #1;
      chk("fl_out_en",    64'(out_en0), 64'(0));
      chk("fl_in_reject", 64'(in_rej0), 64'(0));
      cyc(1);
      flash = 1'b0; in_en0 = '0;
      chk("fl_post_q",  64'(q0), 64'(0));
      chk("fl_post_en", 64'(out_en0), 64'(0));
      out_rej0 = 1'b0;
      in_en0 = 3'b100; in_data0[2*W +: W] = 16'h0077;
      exp0.push_back(16'h0077);
      cyc(1);
      in_en0 = '0;
      chk("fl_byp_en",   64'(out_en0), 64'(1));
      chk("fl_byp_data", 64'(out_data0), 64'(16'h0077));
      cyc(1);
      chk("fl_sb_empty", 64'(exp0.size()), 64'(0));

      // ---- reset mid-stream
      out_rej0 = 1'b1;
      in_en0 = 3'b001; in_data0[0 +: W] = 16'h0040;
      cyc(1);
      in_en0 = 3'b001; in_data0[0 +: W] = 16'h0041;
      chk("mr_pre_en", 64'(out_en0), 64'(1));
      rst_n = 1'b0;
      #1;
      chk("mr_out_en",     64'(out_en0), 64'(0));
      chk("mr_in_reject0", 64'(in_rej0), 64'(3'b111));
      chk("mr_in_reject1", 64'(in_rej1), 64'(3'b111));
      chk("mr_q_count",    64'(q0), 64'(0));
      chk("mr_out_data",   64'(out_data0), 64'(0));
      in_en0 = '0; out_rej0 = 1'b0;
      cyc(2);
      rst_n = 1'b1;
      cyc(1);
      chk("mr_after_en", 64'(out_en0), 64'(0));

      $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
      $finish;
   end

endmodule
